rx_retry_requester: RTL and testbench
=====================================

# rx_retry_requester

Receiver-side link-layer retry requester for the CXL link layer. It watches flits delivered by the unpacker and tracks the expected sequence number (ESeq) and the acknowledgements owed to the remote transmitter. On a CRC error it runs the local retry sequence: RETRY.REQ issue, RETRY.ACK wait with timeout, retry/reinit thresholds and PHY reinit escalation. It sits beside the retry buffer block, between the unpacker and the link-layer controller, and is the requesting end of the retry handshake that the buffer block answers.

## Interface
- No parameters; all limits come from register-file ports.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- unpacker_valid_sig  in  1  flit present this cycle
- unpacker_valid_crc  in  1  flit CRC good (qualified by valid)
- unpacker_flit_type  in  1  0 = protocol flit, 1 = control flit
- unpacker_retry_ack_flag  in  1  control flit is RETRY.ACK
- controller_req_sent_flag  in  1  controller transmitted RETRY.REQ (pulse)
- controller_ack_sent_flag  in  1  controller transmitted an 8-flit ack (pulse)
- i_pl_lnk_up  in  1  physical link up
- i_register_file_retry_threshold  in  5  max RETRY.REQ attempts per reinit
- i_register_file_reinit_threshold  in  5  max PHY reinits before failure
- i_register_file_retry_timeout_max_transfers  in  13  RETRY.ACK timeout, in received flits
- i_register_file_llr_wrap_value  in  8  highest ESeq value before wrap
- o_eseq  out  8  expected sequence number
- o_send_req_seq  out  1  request controller to send RETRY.REQ
- o_ack_req  out  1  ≥8 good protocol flits unacknowledged
- o_discard_flits  out  1  drop received flits (retry in progress)
- o_num_retry  out  5  RETRY.REQ attempts since last reinit/success
- o_num_phy_reinit  out  5  PHY reinits since last success
- o_phy_reinit_req  out  1  one-cycle PHY reinit request
- o_link_failure  out  1  sticky link failure
- o_retry_state  out  3  current FSM state (debug/register file)

## Operation
- Good flit = valid & valid_crc. Bad flit = valid & !valid_crc.
- States: NORMAL, LLRREQ, IDLE (awaiting ACK), PHY_REINIT, ABORT.
- NORMAL:
  - A good protocol flit advances ESeq (llr_wrap_value → 0) and increments the ack counter.
  - A bad flit moves to LLRREQ.
- LLRREQ:
  - If num_retry == retry_threshold: clear num_retry, increment num_phy_reinit, then go to PHY_REINIT. If the incremented value equals reinit_threshold, go to ABORT instead.
  - Otherwise hold o_send_req_seq=1. On controller_req_sent_flag: increment num_retry, clear the timeout counter, go to IDLE.
- IDLE:
  - A good RETRY.ACK control flit clears num_retry and num_phy_reinit and returns to NORMAL.
  - A bad flit returns to LLRREQ.
  - Timeout counter reaching timeout_max returns to LLRREQ.
  - All other flits are ignored.
- PHY_REINIT:
  - o_phy_reinit_req pulses on entry.
  - The FSM waits for i_pl_lnk_up low, then high, then goes to LLRREQ.
- ABORT: terminal until reset; o_link_failure=1.
- o_discard_flits=1 in every state except NORMAL. ESeq and the ack counter are frozen outside NORMAL.
- Ack counter is 8 bits, saturating at 255. o_ack_req = (count ≥ 8). controller_ack_sent_flag subtracts 8 (floor 0). A simultaneous increment and subtract nets −7.
- Counter arithmetic: num_retry and num_phy_reinit are 5-bit, compared with ==. A threshold of 0 escalates on first entry to LLRREQ.

## Timing
- Reset values:
  - o_eseq=0, o_num_retry=0, o_num_phy_reinit=0, ack counter=0
  - o_send_req_seq=0, o_ack_req=0, o_phy_reinit_req=0, o_link_failure=0
  - o_discard_flits=0, state=NORMAL (o_retry_state=0)
- All outputs are registered; a state change is visible 1 cycle after the triggering input.
- o_eseq updates the cycle after a good protocol flit.
- Timeout counter increments once per valid flit (good or bad) while in IDLE. It saturates at timeout_max and triggers on the cycle it equals timeout_max.
- Priority in IDLE: bad flit > good RETRY.ACK > timeout.
- Priority in LLRREQ: threshold check > req_sent.
- A req_sent pulse outside LLRREQ is ignored.
- Asynchronous reset mid-sequence returns all state and counters to reset values immediately.

## Structure
- rx_retry_pkg holds:
  - the state enum (NORMAL=0, LLRREQ=1, IDLE=2, PHY_REINIT=3, ABORT=4)
  - the FLIT_PROTOCOL/FLIT_CONTROL constants
  - ACK_BATCH=8
- One sub-module, retry_timeout_counter: 13-bit counter with clear, flit enable, max input and hit output.

## Test plan
- Wrap: llr_wrap_value=9, 12 good protocol flits → o_eseq sequence 1…9,0,1,2; o_ack_req rises after flit 8; an ack_sent pulse drops the counter to 4.
- Basic retry: bad flit in NORMAL → LLRREQ, o_send_req_seq=1, o_discard_flits=1; req_sent → IDLE, num_retry=1; good RETRY.ACK → NORMAL, num_retry=0, ESeq unchanged.
- Timeout: timeout_max=4, retry_threshold=3; after req_sent, 4 non-ACK flits → LLRREQ; repeat to num_retry=3 → PHY_REINIT with o_phy_reinit_req one-cycle pulse and num_phy_reinit=1.
- Reinit recovery: in PHY_REINIT, drive lnk_up 1→0→1 → LLRREQ; then req_sent plus good ACK → NORMAL with both counters 0.
- Failure: reinit_threshold=2, force two escalations → ABORT, o_link_failure=1 held; an async reset pulse clears all outputs to reset values.
- Simultaneity: a bad flit in the same IDLE cycle as the timeout hit → LLRREQ exactly once, num_retry unchanged until the next req_sent.

Source files
------------

// File: rtl/rx_retry_requester_pkg.sv
// Shared types and constants for the receive-side link-layer retry requester.
package rx_retry_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL     = 3'd0,
    ST_LLRREQ     = 3'd1,
    ST_IDLE       = 3'd2,
    ST_PHY_REINIT = 3'd3,
    ST_ABORT      = 3'd4
  } retry_state_e;

  localparam logic FLIT_PROTOCOL = 1'b0;
  localparam logic FLIT_CONTROL  = 1'b1;

  // Good protocol flits covered by one acknowledgement from the controller.
  localparam int unsigned ACK_BATCH = 8;

  localparam int unsigned TIMEOUT_W = 13;

  // Next ack count: add one good flit, retire a batch if acked (floor 0), saturate at 255.
  function automatic logic [7:0] ack_count_update(input logic [7:0] count,
                                                  input logic       inc,
                                                  input logic       sub);
    logic [8:0] sum;
    sum = {1'b0, count} + {8'd0, inc};
    if (sub) begin
      sum = (sum >= 9'(ACK_BATCH)) ? sum - 9'(ACK_BATCH) : '0;
    end
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/rx_retry_requester_timeout_counter.sv
// Counts flits received while waiting for RETRY.ACK; flags when the limit is reached.
module retry_timeout_counter
  import rx_retry_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 flit_en,
  input  logic [TIMEOUT_W-1:0] max_count,
  output logic                 hit
);

  logic [TIMEOUT_W-1:0] count;

  // Saturating flit counter, restarted each time a new RETRY.REQ goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (flit_en && (count < max_count)) begin
      count <= count + 13'd1;
    end
  end

  assign hit = (count == max_count);

endmodule

// File: rtl/rx_retry_requester.sv
// Receiver-side link-layer retry requester: tracks ESeq and owed acks, and drives the
// local RETRY.REQ / RETRY.ACK sequence with PHY reinit escalation and link failure.
module rx_retry_requester
  import rx_retry_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        unpacker_valid_sig,
  input  logic        unpacker_valid_crc,
  input  logic        unpacker_flit_type,
  input  logic        unpacker_retry_ack_flag,
  input  logic        controller_req_sent_flag,
  input  logic        controller_ack_sent_flag,
  input  logic        i_pl_lnk_up,
  input  logic [4:0]  i_register_file_retry_threshold,
  input  logic [4:0]  i_register_file_reinit_threshold,
  input  logic [12:0] i_register_file_retry_timeout_max_transfers,
  input  logic [7:0]  i_register_file_llr_wrap_value,
  output logic [7:0]  o_eseq,
  output logic        o_send_req_seq,
  output logic        o_ack_req,
  output logic        o_discard_flits,
  output logic [4:0]  o_num_retry,
  output logic [4:0]  o_num_phy_reinit,
  output logic        o_phy_reinit_req,
  output logic        o_link_failure,
  output logic [2:0]  o_retry_state
);

  retry_state_e state;
  retry_state_e state_nxt;
  logic         seen_link_down;
  logic         seen_link_down_nxt;
  logic [4:0]   num_retry_nxt;
  logic [4:0]   num_phy_reinit_nxt;
  logic [4:0]   reinit_inc;
  logic [7:0]   ack_count;
  logic [7:0]   ack_count_nxt;

  logic good_flit;
  logic bad_flit;
  logic good_protocol;
  logic good_retry_ack;
  logic retry_exhausted;
  logic timeout_clear;
  logic timeout_flit_en;
  logic timeout_hit;

  assign good_flit       = unpacker_valid_sig & unpacker_valid_crc;
  assign bad_flit        = unpacker_valid_sig & ~unpacker_valid_crc;
  assign good_protocol   = good_flit & (unpacker_flit_type == FLIT_PROTOCOL);
  assign good_retry_ack  = good_flit & (unpacker_flit_type == FLIT_CONTROL) & unpacker_retry_ack_flag;
  assign retry_exhausted = (o_num_retry == i_register_file_retry_threshold);
  assign reinit_inc      = o_num_phy_reinit + 5'd1;
  assign timeout_clear   = (state == ST_LLRREQ) & ~retry_exhausted & controller_req_sent_flag;
  assign timeout_flit_en = (state == ST_IDLE) & unpacker_valid_sig;

  retry_timeout_counter u_timeout (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (timeout_clear),
    .flit_en   (timeout_flit_en),
    .max_count (i_register_file_retry_timeout_max_transfers),
    .hit       (timeout_hit)
  );

  // Next-state and retry/reinit counter decisions for the retry sequence.
  always_comb begin
    state_nxt          = state;
    num_retry_nxt      = o_num_retry;
    num_phy_reinit_nxt = o_num_phy_reinit;
    seen_link_down_nxt = seen_link_down;
    case (state)
      ST_NORMAL: begin
        if (bad_flit) state_nxt = ST_LLRREQ;
      end
      ST_LLRREQ: begin
        if (retry_exhausted) begin
          num_retry_nxt      = '0;
          num_phy_reinit_nxt = reinit_inc;
          seen_link_down_nxt = 1'b0;
          state_nxt = (reinit_inc == i_register_file_reinit_threshold) ? ST_ABORT : ST_PHY_REINIT;
        end else if (controller_req_sent_flag) begin
          num_retry_nxt = o_num_retry + 5'd1;
          state_nxt     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bad_flit) begin
          state_nxt = ST_LLRREQ;
        end else if (good_retry_ack) begin
          num_retry_nxt      = '0;
          num_phy_reinit_nxt = '0;
          state_nxt          = ST_NORMAL;
        end else if (timeout_hit) begin
          state_nxt = ST_LLRREQ;
        end
      end
      ST_PHY_REINIT: begin
        if (!seen_link_down) begin
          if (!i_pl_lnk_up) seen_link_down_nxt = 1'b1;
        end else if (i_pl_lnk_up) begin
          state_nxt = ST_LLRREQ;
        end
      end
      ST_ABORT: begin
        state_nxt = ST_ABORT;
      end
      default: begin
        state_nxt = ST_NORMAL;
      end
    endcase
  end

  // Retry FSM register; outputs are decoded from the next state so they line up with it.
  // send_req is suppressed when the upcoming LLRREQ cycle will escalate instead of requesting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_NORMAL;
      seen_link_down   <= 1'b0;
      o_num_retry      <= '0;
      o_num_phy_reinit <= '0;
      o_send_req_seq   <= 1'b0;
      o_discard_flits  <= 1'b0;
      o_phy_reinit_req <= 1'b0;
      o_link_failure   <= 1'b0;
    end else begin
      state            <= state_nxt;
      seen_link_down   <= seen_link_down_nxt;
      o_num_retry      <= num_retry_nxt;
      o_num_phy_reinit <= num_phy_reinit_nxt;
      o_send_req_seq   <= (state_nxt == ST_LLRREQ) &&
                          (num_retry_nxt != i_register_file_retry_threshold);
      o_discard_flits  <= (state_nxt != ST_NORMAL);
      o_phy_reinit_req <= (state_nxt == ST_PHY_REINIT) && (state != ST_PHY_REINIT);
      o_link_failure   <= (state_nxt == ST_ABORT);
    end
  end

  assign ack_count_nxt = (state == ST_NORMAL)
                       ? ack_count_update(ack_count, good_protocol, controller_ack_sent_flag)
                       : ack_count;

  // ESeq and outstanding-ack tracking; both frozen while a retry is in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_eseq    <= '0;
      ack_count <= '0;
      o_ack_req <= 1'b0;
    end else begin
      if ((state == ST_NORMAL) && good_protocol) begin
        o_eseq <= (o_eseq == i_register_file_llr_wrap_value) ? '0 : o_eseq + 8'd1;
      end
      ack_count <= ack_count_nxt;
      o_ack_req <= (ack_count_nxt >= 8'(ACK_BATCH));
    end
  end

  assign o_retry_state = state;

endmodule

// File: tb/tb_rx_retry_requester.sv
// Self-checking bench for rx_retry_requester: directed scenarios plus randomized
// stimulus, all checked every cycle against a behavioural reference model.
module tb_rx_retry_requester;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        unpacker_valid_sig = 1'b0;
  logic        unpacker_valid_crc = 1'b0;
  logic        unpacker_flit_type = 1'b0;
  logic        unpacker_retry_ack_flag = 1'b0;
  logic        controller_req_sent_flag = 1'b0;
  logic        controller_ack_sent_flag = 1'b0;
  logic        i_pl_lnk_up = 1'b1;
  logic [4:0]  cfg_retry_thr = 5'd3;
  logic [4:0]  cfg_reinit_thr = 5'd2;
  logic [12:0] cfg_timeout = 13'd4;
  logic [7:0]  cfg_wrap = 8'd9;
  logic [7:0]  o_eseq;
  logic        o_send_req_seq;
  logic        o_ack_req;
  logic        o_discard_flits;
  logic [4:0]  o_num_retry;
  logic [4:0]  o_num_phy_reinit;
  logic        o_phy_reinit_req;
  logic        o_link_failure;
  logic [2:0]  o_retry_state;

  int unsigned n_compared = 0;
  int unsigned n_mismatched = 0;

  rx_retry_requester dut (
    .i_clk                                      (i_clk),
    .i_rst_n                                    (i_rst_n),
    .unpacker_valid_sig                         (unpacker_valid_sig),
    .unpacker_valid_crc                         (unpacker_valid_crc),
    .unpacker_flit_type                         (unpacker_flit_type),
    .unpacker_retry_ack_flag                    (unpacker_retry_ack_flag),
    .controller_req_sent_flag                   (controller_req_sent_flag),
    .controller_ack_sent_flag                   (controller_ack_sent_flag),
    .i_pl_lnk_up                                (i_pl_lnk_up),
    .i_register_file_retry_threshold            (cfg_retry_thr),
    .i_register_file_reinit_threshold           (cfg_reinit_thr),
    .i_register_file_retry_timeout_max_transfers(cfg_timeout),
    .i_register_file_llr_wrap_value             (cfg_wrap),
    .o_eseq                                     (o_eseq),
    .o_send_req_seq                             (o_send_req_seq),
    .o_ack_req                                  (o_ack_req),
    .o_discard_flits                            (o_discard_flits),
    .o_num_retry                                (o_num_retry),
    .o_num_phy_reinit                           (o_num_phy_reinit),
    .o_phy_reinit_req                           (o_phy_reinit_req),
    .o_link_failure                             (o_link_failure),
    .o_retry_state                              (o_retry_state)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: 0 normal, 1 requesting, 2 awaiting ack, 3 phy reinit, 4 abort.
  int m_state, m_eseq, m_ack, m_nretry, m_nreinit, m_flits;
  bit m_seen_low, m_pulse;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_compared++;
    if (obs != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_eseq = 0; m_ack = 0; m_nretry = 0; m_nreinit = 0;
    m_flits = 0; m_seen_low = 0; m_pulse = 0;
  endfunction

  function automatic void model_step();
    bit good, bad, proto, ack_ctl;
    int ns, a;
    good    = unpacker_valid_sig && unpacker_valid_crc;
    bad     = unpacker_valid_sig && !unpacker_valid_crc;
    proto   = good && !unpacker_flit_type;
    ack_ctl = good && unpacker_flit_type && unpacker_retry_ack_flag;
    ns = m_state;
    case (m_state)
      0: begin
        if (proto) m_eseq = (m_eseq == int'(cfg_wrap)) ? 0 : (m_eseq + 1) % 256;
        a = m_ack + (proto ? 1 : 0);
        if (controller_ack_sent_flag) a = (a < 8) ? 0 : a - 8;
        m_ack = (a > 255) ? 255 : a;
        if (bad) ns = 1;
      end
      1: begin
        if (m_nretry == int'(cfg_retry_thr)) begin
          m_nretry = 0;
          m_nreinit = (m_nreinit + 1) % 32;
          m_seen_low = 0;
          ns = (m_nreinit == int'(cfg_reinit_thr)) ? 4 : 3;
        end else if (controller_req_sent_flag) begin
          m_nretry = (m_nretry + 1) % 32;
          m_flits = 0;
          ns = 2;
        end
      end
      2: begin
        if (bad) ns = 1;
        else if (ack_ctl) begin ns = 0; m_nretry = 0; m_nreinit = 0; end
        else if (m_flits == int'(cfg_timeout)) ns = 1;
        if (unpacker_valid_sig && m_flits < int'(cfg_timeout)) m_flits++;
      end
      3: begin
        if (!m_seen_low) begin
          if (!i_pl_lnk_up) m_seen_low = 1;
        end else if (i_pl_lnk_up) ns = 1;
      end
      default: ns = m_state;
    endcase
    m_pulse = (ns == 3) && (m_state != 3);
    m_state = ns;
  endfunction

  task automatic check_outputs();
    check_eq("state", o_retry_state, m_state);
    check_eq("eseq", o_eseq, m_eseq);
    check_eq("ack_req", o_ack_req, (m_ack >= 8) ? 1 : 0);
    check_eq("send_req", o_send_req_seq, (m_state == 1 && m_nretry != int'(cfg_retry_thr)) ? 1 : 0);
    check_eq("discard", o_discard_flits, (m_state != 0) ? 1 : 0);
    check_eq("num_retry", o_num_retry, m_nretry);
    check_eq("num_reinit", o_num_phy_reinit, m_nreinit);
    check_eq("phy_reinit_req", o_phy_reinit_req, m_pulse);
    check_eq("link_failure", o_link_failure, (m_state == 4) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic quiet();
    unpacker_valid_sig = 0; unpacker_valid_crc = 0; unpacker_flit_type = 0;
    unpacker_retry_ack_flag = 0; controller_req_sent_flag = 0; controller_ack_sent_flag = 0;
  endtask

  task automatic flit(input bit crc, input bit ftype, input bit ackf);
    quiet();
    unpacker_valid_sig = 1; unpacker_valid_crc = crc;
    unpacker_flit_type = ftype; unpacker_retry_ack_flag = ackf;
  endtask

  task automatic req_sent();
    quiet();
    controller_req_sent_flag = 1;
  endtask

  // Asynchronous reset asserted away from any clock edge, checked before the next edge.
  task automatic do_reset();
    #($urandom_range(1, 3));
    i_rst_n = 0;
    quiet();
    i_pl_lnk_up = 1;
    #1;
    model_reset();
    check_outputs();
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  task automatic random_inputs();
    unpacker_valid_sig       = ($urandom_range(0, 9) < 6);
    unpacker_valid_crc       = ($urandom_range(0, 9) < 8);
    unpacker_flit_type       = 1'($urandom_range(0, 1));
    unpacker_retry_ack_flag  = ($urandom_range(0, 9) < 4);
    controller_req_sent_flag = ($urandom_range(0, 9) < 3);
    controller_ack_sent_flag = ($urandom_range(0, 9) < 2);
    if ($urandom_range(0, 9) < 2) i_pl_lnk_up = ~i_pl_lnk_up;
  endtask

  // Stimulus that always pushes the sequence towards escalation.
  task automatic drive_towards_failure();
    quiet();
    case (o_retry_state)
      3'd0: flit(0, 0, 0);
      3'd1: controller_req_sent_flag = 1;
      3'd2: flit(1, 0, 0);
      3'd3: i_pl_lnk_up = ~i_pl_lnk_up;
      default: ;
    endcase
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #2;
    check_outputs();
    @(negedge i_clk);
    i_rst_n = 1;

    // ESeq wrap and ack batching
    for (int k = 1; k <= 12; k++) begin
      flit(1, 0, 0);
      tick();
      check_eq("wrap_eseq", o_eseq, k % 10);
      check_eq("wrap_ack_req", o_ack_req, (k >= 8) ? 1 : 0);
    end
    quiet();
    controller_ack_sent_flag = 1;
    tick();
    check_eq("ack_after_sent", o_ack_req, 0);

    // Basic retry handshake
    flit(0, 0, 0);
    tick();
    check_eq("retry_state", o_retry_state, 1);
    check_eq("retry_send_req", o_send_req_seq, 1);
    check_eq("retry_discard", o_discard_flits, 1);
    req_sent();
    tick();
    check_eq("retry_idle", o_retry_state, 2);
    check_eq("retry_nretry", o_num_retry, 1);
    flit(1, 1, 1);
    tick();
    check_eq("retry_normal", o_retry_state, 0);
    check_eq("retry_nretry_clr", o_num_retry, 0);
    check_eq("retry_eseq_held", o_eseq, 2);

    // Timeouts escalate to PHY reinit, then recover
    flit(0, 0, 0);
    tick();
    for (int r = 1; r <= 3; r++) begin
      req_sent();
      tick();
      for (int f = 0; f < 4; f++) begin
        flit(1, 0, 0);
        tick();
      end
      quiet();
      tick();
      check_eq("timeout_llrreq", o_retry_state, 1);
      check_eq("timeout_nretry", o_num_retry, r);
    end
    check_eq("exhausted_no_req", o_send_req_seq, 0);
    quiet();
    tick();
    check_eq("reinit_state", o_retry_state, 3);
    check_eq("reinit_pulse", o_phy_reinit_req, 1);
    check_eq("reinit_count", o_num_phy_reinit, 1);
    tick();
    check_eq("reinit_pulse_end", o_phy_reinit_req, 0);
    i_pl_lnk_up = 0;
    tick();
    i_pl_lnk_up = 1;
    tick();
    check_eq("reinit_to_llrreq", o_retry_state, 1);
    req_sent();
    tick();
    flit(1, 1, 1);
    tick();
    check_eq("recover_state", o_retry_state, 0);
    check_eq("recover_nretry", o_num_retry, 0);
    check_eq("recover_nreinit", o_num_phy_reinit, 0);

    // Bad flit coinciding with timeout hit
    do_reset();
    flit(0, 0, 0);
    tick();
    req_sent();
    tick();
    for (int f = 0; f < 4; f++) begin
      flit(1, 0, 0);
      tick();
    end
    flit(0, 0, 0);
    tick();
    check_eq("simul_state", o_retry_state, 1);
    check_eq("simul_nretry", o_num_retry, 1);
    quiet();
    tick();
    check_eq("simul_hold", o_retry_state, 1);
    check_eq("simul_hold_nretry", o_num_retry, 1);
    req_sent();
    tick();
    check_eq("simul_next_req", o_num_retry, 2);

    // Two escalations with reinit threshold 2 end in abort
    for (int i = 0; i < 400 && !o_link_failure; i++) begin
      drive_towards_failure();
      tick();
    end
    check_eq("abort_reached", o_link_failure, 1);
    for (int i = 0; i < 6; i++) begin
      random_inputs();
      tick();
    end
    check_eq("abort_sticky", o_link_failure, 1);
    check_eq("abort_state", o_retry_state, 4);
    do_reset();
    check_eq("post_abort_rst", o_link_failure, 0);

    // Randomized phases with varied configuration
    for (int p = 0; p < 8; p++) begin
      cfg_retry_thr  = 5'($urandom_range(0, 4));
      cfg_reinit_thr = 5'($urandom_range(0, 4));
      cfg_timeout    = 13'($urandom_range(0, 6));
      cfg_wrap       = (p % 2 == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      do_reset();
      for (int c = 0; c < 400; c++) begin
        random_inputs();
        if (p >= 4 && m_state == 0 && $urandom_range(0, 9) < 7) unpacker_valid_crc = 1;
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
